// File: rtl/spu_writeback.sv
// SPU-lite writeback: per-pipe latency delay lines draining into the
// register file write ports, with newest-value forwarding to six read ports.
module spu_writeback #(
  parameter  int WIDTH   = 128,
  parameter  int SIZE    = 128,
  parameter  int DEPTH   = 8,
  localparam int LOGSIZE = $clog2(SIZE),
  localparam int LW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               even_valid_in,
  input  logic [LW-1:0]      even_lat_in,
  input  logic [LOGSIZE-1:0] even_rt_in,
  input  logic [WIDTH-1:0]   even_data_in,
  input  logic               odd_valid_in,
  input  logic [LW-1:0]      odd_lat_in,
  input  logic [LOGSIZE-1:0] odd_rt_in,
  input  logic [WIDTH-1:0]   odd_data_in,
  input  logic               flush_in,
  output logic               wr_en_even_out,
  output logic               wr_en_odd_out,
  output logic [LOGSIZE-1:0] rt_even_addr_out,
  output logic [LOGSIZE-1:0] rt_odd_addr_out,
  output logic [WIDTH-1:0]   rt_even_data_out,
  output logic [WIDTH-1:0]   rt_odd_data_out,
  input  logic [LOGSIZE-1:0] ra_even_addr_in,
  input  logic [LOGSIZE-1:0] rb_even_addr_in,
  input  logic [LOGSIZE-1:0] rc_even_addr_in,
  input  logic [LOGSIZE-1:0] ra_odd_addr_in,
  input  logic [LOGSIZE-1:0] rb_odd_addr_in,
  input  logic [LOGSIZE-1:0] rc_odd_addr_in,
  input  logic [WIDTH-1:0]   ra_even_rf_in,
  input  logic [WIDTH-1:0]   rb_even_rf_in,
  input  logic [WIDTH-1:0]   rc_even_rf_in,
  input  logic [WIDTH-1:0]   ra_odd_rf_in,
  input  logic [WIDTH-1:0]   rb_odd_rf_in,
  input  logic [WIDTH-1:0]   rc_odd_rf_in,
  output logic [WIDTH-1:0]   ra_even_data_out,
  output logic [WIDTH-1:0]   rb_even_data_out,
  output logic [WIDTH-1:0]   rc_even_data_out,
  output logic [WIDTH-1:0]   ra_odd_data_out,
  output logic [WIDTH-1:0]   rb_odd_data_out,
  output logic [WIDTH-1:0]   rc_odd_data_out,
  output logic [5:0]         fwd_hit_out,
  output logic               collision_err_out,
  output logic               lat_err_out
);

  typedef struct packed {
    logic               v;
    logic [LOGSIZE-1:0] rt;
    logic [WIDTH-1:0]   data;
  } slot_t;

  // Pipe index 0 is even, 1 is odd.
  slot_t line_q [2][DEPTH];
  slot_t line_d [2][DEPTH];
  logic  coll_q, coll_d;
  logic  laterr_q, laterr_d;

  logic               in_v   [2];
  logic [LW-1:0]      in_lat [2];
  logic [LOGSIZE-1:0] in_rt  [2];
  logic [WIDTH-1:0]   in_data[2];

  assign in_v[0]    = even_valid_in;
  assign in_lat[0]  = even_lat_in;
  assign in_rt[0]   = even_rt_in;
  assign in_data[0] = even_data_in;
  assign in_v[1]    = odd_valid_in;
  assign in_lat[1]  = odd_lat_in;
  assign in_rt[1]   = odd_rt_in;
  assign in_data[1] = odd_data_in;

  always_comb begin
    coll_d   = coll_q;
    laterr_d = laterr_q;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < DEPTH-1; j++) line_d[p][j] = line_q[p][j+1];
      line_d[p][DEPTH-1] = '0;
    end
    if (flush_in) begin
      for (int p = 0; p < 2; p++)
        for (int j = 0; j < DEPTH; j++) line_d[p][j].v = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (in_v[p]) begin
          if (int'(in_lat[p]) >= DEPTH) begin
            laterr_d = 1'b1;
          end else begin
            for (int j = 0; j < DEPTH; j++) begin
              if (in_lat[p] == LW'(j)) begin
                if (line_d[p][j].v) coll_d = 1'b1;
                line_d[p][j] = '{v: 1'b1, rt: in_rt[p], data: in_data[p]};
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++)
        for (int j = 0; j < DEPTH; j++) line_q[p][j] <= '0;
      coll_q   <= 1'b0;
      laterr_q <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++)
        for (int j = 0; j < DEPTH; j++) line_q[p][j] <= line_d[p][j];
      coll_q   <= coll_d;
      laterr_q <= laterr_d;
    end
  end

  // Same-register double write: odd wins, even is suppressed.
  assign wr_en_odd_out  = line_q[1][0].v;
  assign wr_en_even_out = line_q[0][0].v &&
    !(line_q[1][0].v && (line_q[1][0].rt == line_q[0][0].rt));
  assign rt_even_addr_out = line_q[0][0].rt;
  assign rt_odd_addr_out  = line_q[1][0].rt;
  assign rt_even_data_out = line_q[0][0].data;
  assign rt_odd_data_out  = line_q[1][0].data;
  assign collision_err_out = coll_q;
  assign lat_err_out       = laterr_q;

  logic [LOGSIZE-1:0] rd_addr[6];
  logic [WIDTH-1:0]   rd_rf  [6];
  logic [WIDTH-1:0]   fwd_data[6];
  logic [5:0]         fwd_hit;

  assign rd_addr[0] = ra_even_addr_in;
  assign rd_addr[1] = rb_even_addr_in;
  assign rd_addr[2] = rc_even_addr_in;
  assign rd_addr[3] = ra_odd_addr_in;
  assign rd_addr[4] = rb_odd_addr_in;
  assign rd_addr[5] = rc_odd_addr_in;
  assign rd_rf[0]   = ra_even_rf_in;
  assign rd_rf[1]   = rb_even_rf_in;
  assign rd_rf[2]   = rc_even_rf_in;
  assign rd_rf[3]   = ra_odd_rf_in;
  assign rd_rf[4]   = rb_odd_rf_in;
  assign rd_rf[5]   = rc_odd_rf_in;

  // Later iterations override: highest slot wins, odd over even at a tie.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      fwd_hit[k]  = 1'b0;
      fwd_data[k] = rd_rf[k];
      for (int j = 0; j < DEPTH; j++) begin
        for (int p = 0; p < 2; p++) begin
          if (line_q[p][j].v && (line_q[p][j].rt == rd_addr[k])) begin
            fwd_hit[k]  = 1'b1;
            fwd_data[k] = line_q[p][j].data;
          end
        end
      end
    end
  end

  assign fwd_hit_out      = fwd_hit;
  assign ra_even_data_out = fwd_data[0];
  assign rb_even_data_out = fwd_data[1];
  assign rc_even_data_out = fwd_data[2];
  assign ra_odd_data_out  = fwd_data[3];
  assign rb_odd_data_out  = fwd_data[4];
  assign rc_odd_data_out  = fwd_data[5];

endmodule

// File: tb/tb_spu_writeback.sv
// Bench for spu_writeback: directed scenarios plus random traffic
// against a timestamp-based model of in-flight results.
module tb_spu_writeback;
  localparam int W  = 128;
  localparam int LS = 7;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          even_valid_in, odd_valid_in, flush_in;
  logic [LW-1:0] even_lat_in, odd_lat_in;
  logic [LS-1:0] even_rt_in, odd_rt_in;
  logic [W-1:0]  even_data_in, odd_data_in;
  logic          wr_en_even_out, wr_en_odd_out;
  logic [LS-1:0] rt_even_addr_out, rt_odd_addr_out;
  logic [W-1:0]  rt_even_data_out, rt_odd_data_out;
  logic [LS-1:0] raddr[6];
  logic [W-1:0]  rrf[6];
  logic [W-1:0]  dout[6];
  logic [5:0]    fwd_hit_out;
  logic          collision_err_out, lat_err_out;

  spu_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .even_valid_in(even_valid_in), .even_lat_in(even_lat_in),
    .even_rt_in(even_rt_in), .even_data_in(even_data_in),
    .odd_valid_in(odd_valid_in), .odd_lat_in(odd_lat_in),
    .odd_rt_in(odd_rt_in), .odd_data_in(odd_data_in),
    .flush_in(flush_in),
    .wr_en_even_out(wr_en_even_out), .wr_en_odd_out(wr_en_odd_out),
    .rt_even_addr_out(rt_even_addr_out), .rt_odd_addr_out(rt_odd_addr_out),
    .rt_even_data_out(rt_even_data_out), .rt_odd_data_out(rt_odd_data_out),
    .ra_even_addr_in(raddr[0]), .rb_even_addr_in(raddr[1]),
    .rc_even_addr_in(raddr[2]), .ra_odd_addr_in(raddr[3]),
    .rb_odd_addr_in(raddr[4]), .rc_odd_addr_in(raddr[5]),
    .ra_even_rf_in(rrf[0]), .rb_even_rf_in(rrf[1]),
    .rc_even_rf_in(rrf[2]), .ra_odd_rf_in(rrf[3]),
    .rb_odd_rf_in(rrf[4]), .rc_odd_rf_in(rrf[5]),
    .ra_even_data_out(dout[0]), .rb_even_data_out(dout[1]),
    .rc_even_data_out(dout[2]), .ra_odd_data_out(dout[3]),
    .rb_odd_data_out(dout[4]), .rc_odd_data_out(dout[5]),
    .fwd_hit_out(fwd_hit_out),
    .collision_err_out(collision_err_out), .lat_err_out(lat_err_out)
  );

  typedef struct {
    int           pipe;
    logic [LS-1:0] rt;
    logic [W-1:0]  data;
    int           wc;
  } ent_t;

  ent_t q[$];
  int   now = 0;
  bit   coll_m = 1'b0;
  int   passes = 0, fails = 0, total = 0;
  int   pin_port = -1;
  logic [LS-1:0] pin_addr = '0;

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, now, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_in();
    even_valid_in = 0; odd_valid_in = 0; flush_in = 0;
    even_lat_in = '0; odd_lat_in = '0;
    even_rt_in = '0; odd_rt_in = '0;
    even_data_in = '0; odd_data_in = '0;
  endtask

  task automatic ins(int p, int lat, int rt, logic [W-1:0] d);
    if (p == 0) begin
      even_valid_in = 1; even_lat_in = LW'(lat);
      even_rt_in = LS'(rt); even_data_in = d;
    end else begin
      odd_valid_in = 1; odd_lat_in = LW'(lat);
      odd_rt_in = LS'(rt); odd_data_in = d;
    end
  endtask

  // Model: each result is written in cycle (accept cycle + lat).
  task automatic model_edge();
    ent_t keep[$];
    ent_t e;
    int lat;
    now++;
    foreach (q[i]) if (q[i].wc >= now) keep.push_back(q[i]);
    q = keep;
    if (flush_in) begin
      q.delete();
    end else begin
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? even_valid_in : odd_valid_in) begin
          lat = (p == 0) ? int'(even_lat_in) : int'(odd_lat_in);
          e.pipe = p;
          e.rt   = (p == 0) ? even_rt_in : odd_rt_in;
          e.data = (p == 0) ? even_data_in : odd_data_in;
          e.wc   = now + lat;
          for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].pipe == p && q[i].wc == e.wc) begin
              q.delete(i);
              coll_m = 1'b1;
            end
          end
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic check_all();
    int ie, io, best;
    logic exp_e;
    ie = -1; io = -1;
    foreach (q[i]) begin
      if (q[i].wc == now && q[i].pipe == 0) ie = i;
      if (q[i].wc == now && q[i].pipe == 1) io = i;
    end
    exp_e = (ie >= 0) && !((io >= 0) && q[io].rt == q[ie].rt);
    chk("wr_en_even", W'(wr_en_even_out), W'(exp_e));
    chk("wr_en_odd", W'(wr_en_odd_out), W'(io >= 0));
    if (exp_e) begin
      chk("addr_even", W'(rt_even_addr_out), W'(q[ie].rt));
      chk("data_even", rt_even_data_out, q[ie].data);
    end
    if (io >= 0) begin
      chk("addr_odd", W'(rt_odd_addr_out), W'(q[io].rt));
      chk("data_odd", rt_odd_data_out, q[io].data);
    end
    chk("collision_err", W'(collision_err_out), W'(coll_m));
    chk("lat_err", W'(lat_err_out), '0);
    for (int k = 0; k < 6; k++) begin
      best = -1;
      foreach (q[i]) begin
        if (q[i].wc >= now && q[i].rt == raddr[k]) begin
          if (best < 0 || q[i].wc > q[best].wc ||
              (q[i].wc == q[best].wc && q[i].pipe == 1))
            best = i;
        end
      end
      chk($sformatf("fwd_hit%0d", k), W'(fwd_hit_out[k]), W'(best >= 0));
      chk($sformatf("fwd_data%0d", k), dout[k],
          (best >= 0) ? q[best].data : rrf[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    clear_in();
    for (int k = 0; k < 6; k++) begin
      raddr[k] = LS'($urandom_range(0, 9));
      rrf[k]   = rnd128();
    end
    if (pin_port >= 0) raddr[pin_port] = pin_addr;
    #1;
    check_all();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [W-1:0] a5;
  int wr_cnt;

  initial begin
    clear_in();
    for (int k = 0; k < 6; k++) begin
      raddr[k] = LS'(k);
      rrf[k] = rnd128();
    end
    #2;
    chk("rst_wr_even", W'(wr_en_even_out), '0);
    chk("rst_wr_odd", W'(wr_en_odd_out), '0);
    chk("rst_addr_even", W'(rt_even_addr_out), '0);
    chk("rst_data_odd", rt_odd_data_out, '0);
    chk("rst_hit", W'(fwd_hit_out), '0);
    chk("rst_pass0", dout[0], rrf[0]);
    chk("rst_pass5", dout[5], rrf[5]);
    chk("rst_coll", W'(collision_err_out), '0);
    @(negedge clk);
    rst_n = 1;

    // Single even result, lat 3, forwarded on ra_even until written.
    a5 = {16{8'hA5}};
    pin_port = 0; pin_addr = 7'd5;
    ins(0, 3, 5, a5);
    step();
    step(); step();
    chk("t1_no_early_wr", W'(wr_en_even_out), '0);
    step();
    chk("t1_wr", W'(wr_en_even_out), W'(1));
    chk("t1_data", rt_even_data_out, a5);
    chk("t1_fwd", dout[0], a5);
    step();
    chk("t1_wr_done", W'(wr_en_even_out), '0);
    chk("t1_pass", dout[0], rrf[0]);
    steps(2);

    // Odd lat 4 and even lat 1 to the same register.
    pin_port = 4; pin_addr = 7'd9;
    ins(1, 4, 9, rnd128());
    ins(0, 1, 9, rnd128());
    step();
    steps(6);

    // Same register, both lat 0: odd write wins.
    pin_port = 0; pin_addr = 7'd7;
    ins(0, 0, 7, rnd128());
    ins(1, 0, 7, rnd128());
    step();
    chk("t3_even_suppr", W'(wr_en_even_out), '0);
    chk("t3_odd_wr", W'(wr_en_odd_out), W'(1));
    steps(2);

    // Collision: lat 2 then lat 1 target the same slot.
    pin_port = -1;
    ins(0, 2, 3, rnd128());
    step();
    ins(0, 1, 4, rnd128());
    step();
    chk("t4_coll", W'(collision_err_out), W'(1));
    wr_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wr_en_even_out) wr_cnt++;
    end
    chk("t4_one_write", W'(wr_cnt), W'(1));

    // Flush with in-flight entries and a same-cycle insertion.
    ins(0, 5, 1, rnd128()); ins(1, 6, 2, rnd128());
    step();
    ins(0, 6, 3, rnd128()); ins(1, 7, 4, rnd128());
    step();
    ins(0, 4, 5, rnd128()); flush_in = 1;
    step();
    wr_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (wr_en_even_out || wr_en_odd_out || (fwd_hit_out != 0)) wr_cnt++;
    end
    chk("t5_flush_quiet", W'(wr_cnt), '0);

    // Asynchronous reset between edges with results in flight.
    ins(0, 6, 2, rnd128()); ins(1, 0, 2, rnd128());
    step();
    #2 rst_n = 0;
    #1;
    q.delete();
    coll_m = 1'b0;
    chk("ar_wr_even", W'(wr_en_even_out), '0);
    chk("ar_wr_odd", W'(wr_en_odd_out), '0);
    chk("ar_hit", W'(fwd_hit_out), '0);
    chk("ar_coll", W'(collision_err_out), '0);
    for (int k = 0; k < 6; k++) chk("ar_pass", dout[k], rrf[k]);
    @(negedge clk);
    rst_n = 1;
    steps(10);

    // Random traffic on a small register window.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 9) < 6)
          ins(p, $urandom_range(0, 7), $urandom_range(0, 9), rnd128());
      if ($urandom_range(0, 99) < 3) flush_in = 1;
      step();
    end
    steps(10);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
